// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART word receiver.
//   byte_state_t : states of the per-byte receiver FSM
//   word_state_t : states of the word assembly FSM
//   clks_per_bit : clock cycles per serial bit for a clock rate in MHz and a baud rate
package uart_pkg;

    typedef enum logic [2:0] {
        B_ARM,
        B_IDLE,
        B_START,
        B_DATA,
        B_STOP
    } byte_state_t;

    typedef enum logic {
        W_IDLE,
        W_COLLECT
    } word_state_t;

    function automatic int clks_per_bit(input int rate_mhz, input int baud);
        return (rate_mhz * 1_000_000) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_word_if.sv
// Serial-in / word-out bundle of the UART word receiver.
//   srx       : serial line toward the receiver (idles high)
//   rx_word   : last complete 32-bit word
//   valid     : one-cycle pulse when rx_word updates
//   frame_err : one-cycle pulse on a low stop bit
//   timeout   : one-cycle pulse when a partial word is abandoned
//   idle      : level, nothing in flight and no bytes collected
// master = the side driving the line, slave = the receiver.
interface uart_rx_word_if;
    logic        srx;
    logic [31:0] rx_word;
    logic        valid;
    logic        frame_err;
    logic        timeout;
    logic        idle;

    modport master (output srx, input rx_word, valid, frame_err, timeout, idle);
    modport slave  (input srx, output rx_word, valid, frame_err, timeout, idle);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: two-flop synchroniser on srx followed by a bit-timing FSM.
//   clk, rst  : clock, synchronous active-high reset
//   srx       : asynchronous serial input, idles high
//   rx_byte   : last received byte (LSB arrives first)
//   byte_done : one-cycle pulse, byte received with a good stop bit
//   byte_err  : one-cycle pulse, stop bit sampled low
//   busy      : a byte is in flight (START, DATA or STOP)
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_RATE = -1,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       srx,
    output logic [7:0] rx_byte,
    output logic       byte_done,
    output logic       byte_err,
    output logic       busy
);

    // Clamp keeps the block elaborating with the default (un-overridden) CLK_RATE.
    localparam int CPB_RAW = clks_per_bit(CLK_RATE, BAUD);
    localparam int CPB     = (CPB_RAW < 2) ? 2 : CPB_RAW;
    localparam int CW      = $clog2(CPB);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);

    logic        s_p0;
    logic        s_p1;
    byte_state_t state;
    logic [CW-1:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;

    // Synchroniser stages; both idle high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_p0 <= 1'b1;
            s_p1 <= 1'b1;
        end else begin
            s_p0 <= srx;
            s_p1 <= s_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= B_ARM;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            byte_done <= 1'b0;
            byte_err  <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            byte_err  <= 1'b0;
            case (state)
                // Wait for one full bit-time of idle line so a reset released
                // mid-frame does not lock onto a data bit as a start bit.
                B_ARM: begin
                    if (!s_p1) begin
                        cnt <= '0;
                    end else if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= B_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                B_IDLE: begin
                    if (!s_p1) begin
                        cnt   <= '0;
                        state <= B_START;
                    end
                end
                // Re-check at the start-bit centre; a high line here is a glitch.
                B_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (s_p1) begin
                            state <= B_IDLE;
                        end else begin
                            bit_idx <= '0;
                            state   <= B_DATA;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                B_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shreg <= {s_p1, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= B_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // Return to IDLE at stop-bit centre so a start bit that follows
                // immediately is still caught on its falling edge.
                B_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt       <= '0;
                        byte_done <= s_p1;
                        byte_err  <= !s_p1;
                        state     <= B_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= B_ARM;
                end
            endcase
        end
    end

    assign rx_byte = shreg;
    assign busy    = !((state == B_IDLE) || (state == B_ARM));

endmodule

// File: rtl/uart_rx_word.sv
// Assembles four consecutive UART bytes, first byte in bits 31:24, into one word.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of uart_rx_word_if (srx in; rx_word, valid,
//              frame_err, timeout, idle out)
// A framing error or an inter-byte gap of TIMEOUT_BITS bit-times discards the
// partial word; TIMEOUT_BITS = 0 disables the gap check.
module uart_rx_word
    import uart_pkg::*;
#(
    parameter int CLK_RATE     = -1,
    parameter int BAUD         = 115200,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_word_if.slave  bus
);

    localparam int CPB_RAW      = clks_per_bit(CLK_RATE, BAUD);
    localparam int CPB          = (CPB_RAW < 2) ? 2 : CPB_RAW;
    localparam int TIMEOUT_CLKS = TIMEOUT_BITS * CPB;
    localparam int TW           = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CLKS - 1);

    logic [7:0]  rx_byte;
    logic        byte_done;
    logic        byte_err;
    logic        busy;

    word_state_t wstate;
    logic [1:0]  n;
    logic [23:0] shift;
    logic [TW-1:0] tcnt;
    logic [31:0] rx_word_r;
    logic        valid_r;
    logic        frame_err_r;
    logic        timeout_r;

    uart_rx_byte #(
        .CLK_RATE (CLK_RATE),
        .BAUD     (BAUD)
    ) u_byte (
        .clk       (clk),
        .rst       (rst),
        .srx       (bus.srx),
        .rx_byte   (rx_byte),
        .byte_done (byte_done),
        .byte_err  (byte_err),
        .busy      (busy)
    );

    // Only the first three bytes need holding; the fourth goes straight into rx_word.
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate      <= W_IDLE;
            n           <= '0;
            shift       <= '0;
            tcnt        <= '0;
            rx_word_r   <= '0;
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
            timeout_r   <= 1'b0;
            if (byte_err) begin
                frame_err_r <= 1'b1;
                n           <= '0;
                shift       <= '0;
                tcnt        <= '0;
                wstate      <= W_IDLE;
            end else if (byte_done) begin
                tcnt <= '0;
                if (n == 2'd3) begin
                    rx_word_r <= {shift, rx_byte};
                    valid_r   <= 1'b1;
                    n         <= '0;
                    shift     <= '0;
                    wstate    <= W_IDLE;
                end else begin
                    shift  <= {shift[15:0], rx_byte};
                    n      <= n + 1'b1;
                    wstate <= W_COLLECT;
                end
            end else if ((TIMEOUT_BITS != 0) && (wstate == W_COLLECT) && !busy) begin
                // Frozen while a byte is in flight, so it can never race byte_done.
                if (tcnt == T_LAST) begin
                    timeout_r <= 1'b1;
                    tcnt      <= '0;
                    n         <= '0;
                    shift     <= '0;
                    wstate    <= W_IDLE;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end
        end
    end

    assign bus.rx_word   = rx_word_r;
    assign bus.valid     = valid_r;
    assign bus.frame_err = frame_err_r;
    assign bus.timeout   = timeout_r;
    assign bus.idle      = !busy && (wstate == W_IDLE);

endmodule
